lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
- Multi-register transfer engine for load-multiple (LM) and store-multiple (SM) instructions.
- Sits between the memory stage and the register file.
- Walks an 8-bit register mask lowest index first, performing one transfer per cycle:
  - LM: drives the register file write port.
  - SM: drives a register file read port.
- Holds the pipeline stalled for the whole operation.

Parameters:
- DATA_W, 16, register/memory data width
- REG_AW, 3, register address width
- NREG, 8, number of architectural registers (mask width)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request pulse; sampled only in IDLE
- is_load  input  1  1 = LM, 0 = SM; latched with start
- mask  input  NREG  register select mask, bit k = Rk; latched with start
- base_addr  input  DATA_W  first memory address; latched with start
- mem_rdata  input  DATA_W  combinational memory read data for mem_addr
- rf_data  input  DATA_W  register file read data for rf_read_address
- mem_addr  output  DATA_W  memory address of the current transfer
- mem_we  output  1  memory write strobe (SM)
- mem_wdata  output  DATA_W  store data (SM)
- rf_read_address  output  REG_AW  register file read select (SM)
- rf_write_en  output  1  register file write enable (LM)
- rf_write_address  output  REG_AW  register file write select (LM)
- rf_write_data  output  DATA_W  register file write data (LM)
- stall  output  1  freeze upstream pipeline stages
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - Synchronous, active-high. The clock is clk and the reset is rst.
  - Reset forces IDLE and clears latched mask, base and offset.
  - Reset forces all outputs to 0.
  - Reset asserted mid-operation aborts immediately; no further transfers occur and done does not pulse.
- States: IDLE, ACTIVE, DONE (2-bit encoding).
- IDLE:
  - On start = 1, latch is_load, mask and base_addr, and clear offset to 0.
  - Next state is ACTIVE if mask != 0, otherwise DONE.
  - All outputs are 0 in IDLE.
- ACTIVE (one transfer per cycle):
  - k = index of the lowest set bit of the remaining mask.
  - mem_addr = base + offset, 16-bit modulo; 0xFFFF + 1 wraps to 0x0000.
  - SM:
    - rf_read_address = k.
    - mem_we = 1, mem_wdata = rf_data, same cycle.
    - A store of R7 stores the value the register file returns for R7, i.e. the current PC.
  - LM:
    - rf_write_en = 1, rf_write_address = k, rf_write_data = mem_rdata.
    - The register file commits the write on the next posedge.
    - For k = 7, rf_write_en is forced to 0 because R7 is PC, but the memory slot is still consumed (offset still advances).
  - At the posedge, clear bit k and increment offset.
  - Next state is DONE when the remaining mask becomes 0.
- DONE:
  - done = 1 for exactly one cycle; no transfer strobes.
  - Next state is IDLE.
- stall = 1 whenever state != IDLE.
- start is ignored in ACTIVE and DONE. There is no queueing; upstream must hold the instruction while stalled.
- Latency: n set bits gives transfers in cycles 1..n after start is sampled, done in cycle n+1, IDLE in cycle n+2. mask = 0 gives done in cycle 1.
- Unused read/write address and data outputs are driven to 0 when their strobe is 0.

Decomposition:
- Shared package (pipeline defs):
  - State encoding constants ST_IDLE = 0, ST_ACTIVE = 1, ST_DONE = 2.
  - DATA_W, REG_AW and NREG defaults.
  - PC_REG = 3'd7.
- Sub-module prio_enc8: combinational lowest-set-bit encoder on 8 bits.
  - Outputs index[2:0] and valid.
  - Instantiated once on the remaining mask.

Test Plan:
- Reset: rst = 1 for 2 cycles mid-LM -> next cycle stall = 0, all strobes 0, no done pulse, IDLE accepts a fresh start.
- LM: mask = 8'b0010_0101, base = 0x0040, memory {0x40:0xAAAA, 0x41:0xBBBB, 0x42:0xCCCC} -> R0 = 0xAAAA, R2 = 0xBBBB, R5 = 0xCCCC on cycles 1-3; done on cycle 4; stall high cycles 1-4.
- SM with wrap and R7: mask = 8'h81, base = 0xFFFF, R0 = 0x1234, PC = 0x1000 -> mem[0xFFFF] = 0x1234, mem[0x0000] = 0x1000; rf_write_en never asserted.
- LM with bit 7: mask = 8'h80, base = 0x0010 -> mem_addr = 0x0010 on cycle 1; rf_write_en = 0; R0-R6 unchanged; done on cycle 2.
- Empty mask: start with mask = 0 -> no mem_we and no rf_write_en; done on cycle 1; stall high cycle 1 only.
- Start while busy: second start pulse during ACTIVE with a different mask -> ignored; original transfer sequence and done timing unchanged.

Source files
------------

// File: rtl/lm_sm_sequencer_pkg.sv
// Shared pipeline definitions for the load-multiple / store-multiple sequencer.
//   - FSM state encoding
//   - default data, register-address and mask widths
//   - PC register index (R7)
package lm_sm_sequencer_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_REG_AW = 3;
    localparam int unsigned DEF_NREG   = 8;

    localparam logic [2:0] PC_REG = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/lm_sm_sequencer_prio_enc8.sv
// Lowest-set-bit priority encoder on an 8-bit vector.
//   bits  : input vector
//   index : position of the lowest set bit (0 when none)
//   valid : 1 when any bit is set
module prio_enc8 (
    input  logic [7:0] bits,
    output logic [2:0] index,
    output logic       valid
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        index = 3'd0;
        valid = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) begin
                index = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple transfer engine between the memory stage and
// the register file. Walks the register mask lowest index first, one transfer
// per cycle, and stalls the pipeline until the operation completes.
//   clk, rst          : clock, synchronous active-high reset
//   start, is_load,
//   mask, base_addr   : request, latched in IDLE
//   mem_rdata         : memory read data for mem_addr (LM)
//   rf_data           : register file read data for rf_read_address (SM)
//   mem_addr, mem_we,
//   mem_wdata         : memory side of the current transfer
//   rf_read_address   : register file read select (SM)
//   rf_write_en/_address/_data : register file write port (LM)
//   stall             : freeze upstream stages while busy
//   done              : one-cycle completion pulse
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned NREG   = DEF_NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic [NREG-1:0]   mask,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [REG_AW-1:0] rf_read_address,
    output logic              rf_write_en,
    output logic [REG_AW-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              stall,
    output logic              done
);

    state_t            state, state_d;
    logic              load_q, load_d;
    logic [NREG-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] offset_q, offset_d;

    logic [2:0]        idx;
    logic              idx_valid;

    prio_enc8 u_prio_enc8 (
        .bits  (mask_q),
        .index (idx),
        .valid (idx_valid)
    );

    // State and operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            load_q   <= 1'b0;
            mask_q   <= '0;
            base_q   <= '0;
            offset_q <= '0;
        end else begin
            state    <= state_d;
            load_q   <= load_d;
            mask_q   <= mask_d;
            base_q   <= base_d;
            offset_q <= offset_d;
        end
    end

    // Next-state and transfer outputs.
    always_comb begin
        state_d          = state;
        load_d           = load_q;
        mask_d           = mask_q;
        base_d           = base_q;
        offset_d         = offset_q;
        mem_addr         = '0;
        mem_we           = 1'b0;
        mem_wdata        = '0;
        rf_read_address  = '0;
        rf_write_en      = 1'b0;
        rf_write_address = '0;
        rf_write_data    = '0;
        stall            = (state != ST_IDLE);
        done             = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_d   = is_load;
                    mask_d   = mask;
                    base_d   = base_addr;
                    offset_d = '0;
                    state_d  = (mask != '0) ? ST_ACTIVE : ST_DONE;
                end
            end

            ST_ACTIVE: begin
                mem_addr = base_q + offset_q;
                if (load_q) begin
                    // R7 is the PC: its slot is consumed but never written.
                    if (idx != PC_REG) begin
                        rf_write_en      = 1'b1;
                        rf_write_address = REG_AW'(idx);
                        rf_write_data    = mem_rdata;
                    end
                end else begin
                    rf_read_address = REG_AW'(idx);
                    mem_we          = 1'b1;
                    mem_wdata       = rf_data;
                end
                mask_d   = mask_q & ~(NREG'(1) << idx);
                offset_d = offset_q + DATA_W'(1);
                if (!idx_valid || (mask_d == '0)) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset cancels the in-flight transfer in the same cycle.
        if (rst) begin
            mem_addr         = '0;
            mem_we           = 1'b0;
            mem_wdata        = '0;
            rf_read_address  = '0;
            rf_write_en      = 1'b0;
            rf_write_address = '0;
            rf_write_data    = '0;
            stall            = 1'b0;
            done             = 1'b0;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer: a cycle-by-cycle vector table
// plus hand-written reset and register/memory content checks.
module tb_lm_sm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_load;
    logic [7:0]  mask;
    logic [15:0] base_addr;
    logic [15:0] mem_rdata;
    logic [15:0] rf_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [2:0]  rf_read_address;
    logic        rf_write_en;
    logic [2:0]  rf_write_address;
    logic [15:0] rf_write_data;
    logic        stall;
    logic        done;

    int checks = 0;
    int errors = 0;
    int r7_writes = 0;

    logic [15:0] mem [65536];
    logic [15:0] rf  [8];

    lm_sm_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .is_load          (is_load),
        .mask             (mask),
        .base_addr        (base_addr),
        .mem_rdata        (mem_rdata),
        .rf_data          (rf_data),
        .mem_addr         (mem_addr),
        .mem_we           (mem_we),
        .mem_wdata        (mem_wdata),
        .rf_read_address  (rf_read_address),
        .rf_write_en      (rf_write_en),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .stall            (stall),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign rf_data   = rf[rf_read_address];

    // Memory and register file models commit on the rising edge.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (rf_write_en) begin
            rf[rf_write_address] <= rf_write_data;
            if (rf_write_address == 3'd7) r7_writes <= r7_writes + 1;
        end
    end

    logic [57:0] obs;
    assign obs = {mem_addr, mem_we, mem_wdata, rf_read_address, rf_write_en,
                  rf_write_address, rf_write_data, stall, done};

    typedef struct {
        logic        start;
        logic        ld;
        logic [7:0]  mask;
        logic [15:0] base;
        logic [57:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic ld, input logic [7:0] m,
                                input logic [15:0] b, input logic [15:0] ea,
                                input logic emwe, input logic [15:0] emwd,
                                input logic [2:0] era, input logic erwe,
                                input logic [2:0] erwa, input logic [15:0] erwd,
                                input logic estall, input logic edone);
        vec_t v;
        v.start = st;
        v.ld    = ld;
        v.mask  = m;
        v.base  = b;
        v.exp   = {ea, emwe, emwd, era, erwe, erwa, erwd, estall, edone};
        return v;
    endfunction

    task automatic check_obs(input string name, input logic [57:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    logic [15:0] rf_exp [8];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 7; i++) rf[i] = 16'hA000 + 16'(i);
        rf[7] = 16'h1000;
        mem[16'h0030] = 16'h1234;
        mem[16'h0031] = 16'hDEAD;
        mem[16'h0032] = 16'hBEEF;
        mem[16'h0040] = 16'hAAAA;
        mem[16'h0041] = 16'hBBBB;
        mem[16'h0042] = 16'hCCCC;
        mem[16'h0010] = 16'h5555;
        mem[16'h0020] = 16'h1111;
        mem[16'h0021] = 16'h2222;

        rst = 1'b1; start = 1'b0; is_load = 1'b0; mask = 8'h00; base_addr = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1 check_obs("reset_idle", 58'h0);

        // Reset aborts an LM in flight: R0 written, R1 never.
        @(negedge clk); start = 1'b1; is_load = 1'b1; mask = 8'hFF; base_addr = 16'h0030;
        #1 check_obs("rst_seq_idle", 58'h0);
        @(negedge clk); start = 1'b0;
        #1 check_obs("rst_seq_xfer0", {16'h0030, 1'b0, 16'h0, 3'd0, 1'b1, 3'd0, 16'h1234, 1'b1, 1'b0});
        @(negedge clk); rst = 1'b1;
        #1 check_obs("rst_held_1", 58'h0);
        @(negedge clk);
        #1 check_obs("rst_held_2", 58'h0);
        @(negedge clk); rst = 1'b0;
        #1 check_obs("rst_release", 58'h0);
        @(negedge clk);
        #1 check_obs("rst_no_done", 58'h0);
        check_val("rst_r1_untouched", rf[1], 16'hA001);
        check_val("rst_r0_written", rf[0], 16'h1234);

        // SM with address wrap and R7 (PC) store.
        vecs.push_back(mk(1, 0, 8'h81, 16'hFFFF, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'hFFFF, 1, 16'h1234, 0, 0, 0, 16'h0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0000, 1, 16'h1000, 7, 0, 0, 16'h0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 1, 1));
        // LM R0, R2, R5.
        vecs.push_back(mk(1, 1, 8'h25, 16'h0040, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0040, 0, 16'h0, 0, 1, 0, 16'hAAAA, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0041, 0, 16'h0, 0, 1, 2, 16'hBBBB, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0042, 0, 16'h0, 0, 1, 5, 16'hCCCC, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 1, 1));
        // LM of R7 only: slot consumed, no write.
        vecs.push_back(mk(1, 1, 8'h80, 16'h0010, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0010, 0, 16'h0, 0, 0, 0, 16'h0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 1, 1));
        // Empty mask: straight to DONE.
        vecs.push_back(mk(1, 1, 8'h00, 16'h1234, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));
        // Start pulses while busy are ignored.
        vecs.push_back(mk(1, 1, 8'h06, 16'h0020, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));
        vecs.push_back(mk(1, 0, 8'hFF, 16'h0000, 16'h0020, 0, 16'h0, 0, 1, 1, 16'h1111, 1, 0));
        vecs.push_back(mk(1, 1, 8'h01, 16'h0050, 16'h0021, 0, 16'h0, 0, 1, 2, 16'h2222, 1, 0));
        vecs.push_back(mk(1, 0, 8'hFF, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 16'h0000, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start     = vecs[i].start;
            is_load   = vecs[i].ld;
            mask      = vecs[i].mask;
            base_addr = vecs[i].base;
            #1 check_obs($sformatf("vec%0d", i), vecs[i].exp);
        end

        @(negedge clk);
        check_val("mem_ffff", mem[16'hFFFF], 16'h1234);
        check_val("mem_0000", mem[16'h0000], 16'h1000);
        rf_exp[0] = 16'hAAAA; rf_exp[1] = 16'h1111; rf_exp[2] = 16'h2222;
        rf_exp[3] = 16'hA003; rf_exp[4] = 16'hA004; rf_exp[5] = 16'hCCCC;
        rf_exp[6] = 16'hA006; rf_exp[7] = 16'h1000;
        for (int i = 0; i < 8; i++) check_val($sformatf("rf_r%0d", i), rf[i], rf_exp[i]);
        check_val("r7_write_count", 16'(r7_writes), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
